// File: rtl/pcs_tx_width_adapter_if.sv
// MAC-side word bus and encoder-side symbol bus of the PCS TX width adapter.
// master: the MAC/encoder environment; slave: the adapter itself.
interface pcs_tx_width_adapter_if #(
  parameter int unsigned MAX_BYTES = 4
);
  logic [5:0]             DataBusWidth;
  logic [8*MAX_BYTES-1:0] MAC_TX_Data;
  logic [MAX_BYTES-1:0]   MAC_TX_Datak;
  logic                   MAC_Data_En;
  logic                   MAC_Ready;
  logic [7:0]             Sym_Data;
  logic                   Sym_K;
  logic                   Sym_Valid;
  logic                   Sym_Ready;

  modport master (
    output DataBusWidth, MAC_TX_Data, MAC_TX_Datak, MAC_Data_En, Sym_Ready,
    input  MAC_Ready, Sym_Data, Sym_K, Sym_Valid
  );

  modport slave (
    input  DataBusWidth, MAC_TX_Data, MAC_TX_Datak, MAC_Data_En, Sym_Ready,
    output MAC_Ready, Sym_Data, Sym_K, Sym_Valid
  );
endinterface

// File: rtl/pcs_tx_width_adapter.sv
// PCS TX width adapter: serialises 8/16/32-bit MAC words into a byte-wide
// symbol stream (LSB first) with a valid/ready handshake toward the encoder.
// Optional SKP ordered-set insertion is enabled by defining PCS_SKP_INSERT_EN.
module pcs_tx_width_adapter #(
  parameter int unsigned MAX_BYTES    = 4,
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3
) (
  input logic                   PCLK,
  input logic                   RST_n,
  pcs_tx_width_adapter_if.slave bus
);

  // Reject illegal configurations at elaboration time.
  if (!(MAX_BYTES == 1 || MAX_BYTES == 2 || MAX_BYTES == 4)) begin : g_bad_max_bytes
    $error("pcs_tx_width_adapter: MAX_BYTES must be 1, 2 or 4");
  end
  if (SKP_INTERVAL == 0 || SKP_INTERVAL > 65535 || SKP_COUNT > 255) begin : g_bad_skp_cfg
    $error("pcs_tx_width_adapter: SKP_INTERVAL/SKP_COUNT out of range");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StSkp   = 2'd2;

  localparam logic [7:0] SymCom = 8'hBC;
  localparam logic [7:0] SymSkp = 8'h1C;

  logic [1:0]             state_q, state_d;
  logic [8*MAX_BYTES-1:0] word_q, word_d;
  logic [MAX_BYTES-1:0]   k_q, k_d;
  logic [1:0]             last_q, last_d;     // index of last byte (N-1), latched per word
  logic [1:0]             idx_q, idx_d;
  logic [7:0]             sym_data_q, sym_data_d;
  logic                   sym_k_q, sym_k_d;
  logic                   sym_valid_q, sym_valid_d;

  logic       mac_ready;
  logic       sym_hs;
  logic       accept;
  logic       at_last;
  logic [1:0] idx_inc;
  logic [1:0] width_last;
  logic       skp_due;    // ordered set must be sent at this word boundary

  assign sym_hs  = sym_valid_q & bus.Sym_Ready;
  assign accept  = bus.MAC_Data_En & mac_ready;
  assign at_last = (idx_q == last_q);
  assign idx_inc = idx_q + 2'd1;

  // Decode the active MAC width into N-1; anything unsupported falls back to one byte.
  always_comb begin
    width_last = 2'd0;
    if (bus.DataBusWidth == 6'd16 && MAX_BYTES >= 2) begin
      width_last = 2'd1;
    end else if (bus.DataBusWidth == 6'd32 && MAX_BYTES == 4) begin
      width_last = 2'd3;
    end
  end

`ifdef PCS_SKP_INSERT_EN
  logic [15:0] sym_cnt_q, sym_cnt_d;
  logic        skp_pend_q, skp_pend_d;
  logic [7:0]  skp_idx_q, skp_idx_d;
  logic        cnt_hit;

  // The handshake that brings the counter to the interval counts as due immediately,
  // so the ordered set follows the word that contains that symbol without delay.
  assign cnt_hit = sym_hs && ((sym_cnt_q + 16'd1) == 16'(SKP_INTERVAL));
  assign skp_due = skp_pend_q | cnt_hit;

  // Symbol counter, pending flag and position inside the ordered set.
  always_comb begin
    sym_cnt_d  = sym_cnt_q;
    skp_pend_d = skp_pend_q;
    skp_idx_d  = skp_idx_q;
    if (sym_hs) begin
      sym_cnt_d = sym_cnt_q + 16'd1;
    end
    if (cnt_hit) begin
      skp_pend_d = 1'b1;
    end
    if (state_q != StSkp) begin
      skp_idx_d = 8'd0;
    end else if (sym_hs) begin
      if (skp_idx_q == 8'(SKP_COUNT)) begin
        skp_pend_d = 1'b0;
        sym_cnt_d  = 16'd0;
        skp_idx_d  = 8'd0;
      end else begin
        skp_idx_d = skp_idx_q + 8'd1;
      end
    end
  end

  // SKP bookkeeping registers.
  always_ff @(posedge PCLK or negedge RST_n) begin
    if (!RST_n) begin
      sym_cnt_q  <= 16'd0;
      skp_pend_q <= 1'b0;
      skp_idx_q  <= 8'd0;
    end else begin
      sym_cnt_q  <= sym_cnt_d;
      skp_pend_q <= skp_pend_d;
      skp_idx_q  <= skp_idx_d;
    end
  end
`else
  assign skp_due = 1'b0;
`endif

  // MAC_Ready: open in IDLE, and in SHIFT only when the last byte leaves this cycle.
  always_comb begin
    case (state_q)
      StIdle:  mac_ready = ~skp_due;
      StShift: mac_ready = at_last & bus.Sym_Ready & ~skp_due;
      default: mac_ready = 1'b0;
    endcase
  end

  // Next-state logic: word load, byte shifting and ordered-set emission.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    k_d         = k_q;
    last_d      = last_q;
    idx_d       = idx_q;
    sym_data_d  = sym_data_q;
    sym_k_d     = sym_k_q;
    sym_valid_d = sym_valid_q;
    case (state_q)
      StIdle: begin
`ifdef PCS_SKP_INSERT_EN
        if (skp_due) begin
          state_d     = StSkp;
          sym_data_d  = SymCom;
          sym_k_d     = 1'b1;
          sym_valid_d = 1'b1;
        end else
`endif
        if (accept) begin
          state_d     = StShift;
          word_d      = bus.MAC_TX_Data;
          k_d         = bus.MAC_TX_Datak;
          last_d      = width_last;
          idx_d       = 2'd0;
          sym_data_d  = bus.MAC_TX_Data[7:0];
          sym_k_d     = bus.MAC_TX_Datak[0];
          sym_valid_d = 1'b1;
        end
      end
      StShift: begin
        if (sym_hs) begin
          if (!at_last) begin
            idx_d      = idx_inc;
            sym_data_d = word_q[{idx_inc, 3'b000} +: 8];
            sym_k_d    = k_q[idx_inc];
          end
`ifdef PCS_SKP_INSERT_EN
          else if (skp_due) begin
            state_d     = StSkp;
            idx_d       = 2'd0;
            sym_data_d  = SymCom;
            sym_k_d     = 1'b1;
            sym_valid_d = 1'b1;
          end
`endif
          else if (accept) begin
            // Back-to-back reload: byte 0 of the new word follows with no bubble.
            word_d      = bus.MAC_TX_Data;
            k_d         = bus.MAC_TX_Datak;
            last_d      = width_last;
            idx_d       = 2'd0;
            sym_data_d  = bus.MAC_TX_Data[7:0];
            sym_k_d     = bus.MAC_TX_Datak[0];
            sym_valid_d = 1'b1;
          end else begin
            state_d     = StIdle;
            idx_d       = 2'd0;
            sym_valid_d = 1'b0;
          end
        end
      end
`ifdef PCS_SKP_INSERT_EN
      StSkp: begin
        if (sym_hs) begin
          if (skp_idx_q == 8'(SKP_COUNT)) begin
            state_d     = StIdle;
            sym_valid_d = 1'b0;
          end else begin
            sym_data_d = SymSkp;
            sym_k_d    = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d     = StIdle;
        idx_d       = 2'd0;
        sym_valid_d = 1'b0;
      end
    endcase
  end

  // Main state and output registers; reset discards any word in flight.
  always_ff @(posedge PCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= StIdle;
      word_q      <= '0;
      k_q         <= '0;
      last_q      <= 2'd0;
      idx_q       <= 2'd0;
      sym_data_q  <= 8'h00;
      sym_k_q     <= 1'b0;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      k_q         <= k_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      sym_data_q  <= sym_data_d;
      sym_k_q     <= sym_k_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign bus.MAC_Ready = mac_ready;
  assign bus.Sym_Data  = sym_data_q;
  assign bus.Sym_K     = sym_k_q;
  assign bus.Sym_Valid = sym_valid_q;

endmodule
